// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The slave modport is the loader; the master modport is the host/memory side.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 6
);
  // Handshake: a byte moves on a rising edge where rx_valid & rx_ready are both 1.
  // The source holds rx_data stable while rx_valid is high and rx_ready is low.
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: framed byte stream in, little-endian words out,
// CPU held in reset until a checksum-verified program has been written.
module imem_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  imem_loader_if.slave        bus,
  output logic                cpu_reset,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [2:0]          dbg_state
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN0  = 3'd1;
  localparam logic [2:0] S_LEN1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

  logic [2:0]          state, next_state;
  logic [1:0]          byte_cnt;
  logic [ADDR_WIDTH:0] word_idx;
  logic [7:0]          len_lo;
  logic [15:0]         len;
  logic [7:0]          checksum;
  logic [23:0]         asm_reg;
  logic                accept;
  logic [15:0]         len_full;
  logic                last_word;
  logic                next_busy;

  assign dbg_state = state;
  assign accept    = bus.rx_valid & bus.rx_ready;
  assign len_full  = {bus.rx_data, len_lo};
  assign last_word = (16'(word_idx) == (len - 16'd1)) && (byte_cnt == 2'd3);
  assign next_busy = (next_state == S_LEN0) || (next_state == S_LEN1) ||
                     (next_state == S_DATA) || (next_state == S_CHECK);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) next_state = S_LEN0;
      S_LEN0: if (accept) next_state = S_LEN1;
      S_LEN1:
        if (accept) begin
          if ({1'b0, len_full} > CAPACITY) next_state = S_ERROR;
          else if (len_full == 16'd0)      next_state = S_CHECK;
          else                             next_state = S_DATA;
        end
      S_DATA:  if (accept && last_word) next_state = S_CHECK;
      S_CHECK: if (accept) next_state = (bus.rx_data == checksum) ? S_DONE : S_ERROR;
      default: next_state = S_IDLE;
    endcase
  end

  // Status outputs are registered from next_state so they track the state with no lag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      byte_cnt       <= '0;
      word_idx       <= '0;
      len_lo         <= '0;
      len            <= '0;
      checksum       <= '0;
      asm_reg        <= '0;
      bus.rx_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      cpu_reset      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state        <= next_state;
      bus.imem_we  <= 1'b0;
      bus.rx_ready <= next_busy;
      busy         <= next_busy;
      done         <= (next_state == S_DONE);
      error        <= (next_state == S_ERROR);
      cpu_reset    <= (next_state != S_DONE);
      case (state)
        S_IDLE, S_DONE, S_ERROR:
          if (start) begin
            byte_cnt <= '0;
            word_idx <= '0;
            checksum <= '0;
          end
        S_LEN0: if (accept) len_lo <= bus.rx_data;
        S_LEN1: if (accept) len <= len_full;
        S_DATA:
          if (accept) begin
            checksum <= checksum + bus.rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: asm_reg[7:0]   <= bus.rx_data;
              2'd1: asm_reg[15:8]  <= bus.rx_data;
              2'd2: asm_reg[23:16] <= bus.rx_data;
              default: begin
                bus.imem_we    <= 1'b1;
                bus.imem_addr  <= word_idx[ADDR_WIDTH-1:0];
                bus.imem_wdata <= {bus.rx_data, asm_reg};
                word_idx       <= word_idx + 1'b1;
              end
            endcase
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are driven byte by byte, expected
// memory writes are queued per frame and matched against imem_we as it fires.
module tb_imem_loader;
  localparam int AW = 6;
  localparam logic [2:0] S_IDLE = 3'd0;

  logic       clk;
  logic       reset;
  logic       start;
  logic       cpu_reset, busy, done, error;
  logic [2:0] dbg_state;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus.slave),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  logic [AW+31:0] exp_q[$];
  logic [31:0]    prog[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_we", {bus.imem_addr, bus.imem_wdata}, 0);
      else check("imem_write", {bus.imem_addr, bus.imem_wdata}, exp_q.pop_front());
    end
  end

  // driver tasks: all leave the bench just after a rising edge
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int n;
    repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("rx_ready_timeout", 0, 1);
    else begin @(posedge clk); #1; end
    bus.rx_valid = 1'b0;
  endtask

  // Drives start plus a whole frame built from prog; the checksum is summed here
  // from the data bytes and optionally corrupted by chk_adj.
  task automatic run_frame(input int gap_max, input logic [7:0] chk_adj, input bit poke_start);
    logic [7:0] sum;
    logic [31:0] w;
    int n;
    n = prog.size();
    sum = 8'h00;
    pulse_start();
    check("start_busy", busy, 1);
    check("start_rx_ready", bus.rx_ready, 1);
    check("start_cpu_reset", cpu_reset, 1);
    check("start_done", done, 0);
    for (int i = 0; i < n; i++) exp_q.push_back({AW'(i), prog[i]});
    send_byte(n[7:0], gap_max);
    send_byte(n[15:8], gap_max);
    for (int i = 0; i < n; i++) begin
      w = prog[i];
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], gap_max);
        sum = sum + w[8*k +: 8];
        if (poke_start && k == 1) pulse_start();
      end
    end
    send_byte(sum + chk_adj, gap_max);
    check("frame_writes_pending", exp_q.size(), 0);
    check("frame_busy", busy, 0);
    check("frame_rx_ready", bus.rx_ready, 0);
    check("frame_done", done, (chk_adj == 0));
    check("frame_error", error, (chk_adj != 0));
    check("frame_cpu_reset", cpu_reset, (chk_adj != 0));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", dbg_state, S_IDLE);
    check("rst_outputs", {bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata},
          {2'b00, AW'(0), 32'h0});
    check("rst_status", {cpu_reset, busy, done, error}, 4'b1000);
    reset = 1'b0;
    @(posedge clk); #1;

    // normal load
    prog = '{32'h12345678, 32'hDEADBEEF};
    run_frame(0, 8'h00, 1'b0);

    // bad checksum, then stray rx_valid in ERROR must be ignored
    run_frame(0, 8'h01, 1'b0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h55;
    repeat (3) begin @(posedge clk); #1; end
    bus.rx_valid = 1'b0;
    check("error_hold", {error, cpu_reset, busy, bus.rx_ready}, 4'b1100);

    // empty program, good and bad checksum
    prog = '{};
    run_frame(0, 8'h00, 1'b0);
    run_frame(0, 8'h01, 1'b0);

    // oversize: N = 65
    pulse_start();
    send_byte(8'h41, 0);
    send_byte(8'h00, 0);
    check("oversize_error", error, 1);
    check("oversize_rx_ready", bus.rx_ready, 0);
    check("oversize_cpu_reset", cpu_reset, 1);
    repeat (2) begin @(posedge clk); #1; end

    // full capacity: N = 64 accepted
    prog = '{};
    for (int i = 0; i < 64; i++) prog.push_back($urandom());
    run_frame(0, 8'h00, 1'b0);

    // backpressure
    prog = '{32'h12345678, 32'hDEADBEEF};
    run_frame(3, 8'h00, 1'b0);

    // reset after three data bytes
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    send_byte(8'h34, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midword_rst_state", dbg_state, S_IDLE);
    check("midword_rst_status", {cpu_reset, busy, done, error, bus.rx_ready}, 5'b10000);
    repeat (3) begin @(posedge clk); #1; end
    run_frame(0, 8'h00, 1'b0);

    // start pulses while busy are ignored; random words with gaps
    prog = '{};
    for (int i = 0; i < 5; i++) prog.push_back($urandom());
    run_frame(2, 8'h00, 1'b1);

    // restart from DONE
    prog = '{32'hCAFEF00D};
    run_frame(1, 8'h00, 1'b0);

    repeat (3) begin @(posedge clk); #1; end
    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
